regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-read-port register file with registered read outputs, same-cycle write-to-read bypass, two write ports and a per-register busy scoreboard. It sits between operand fetch and writeback in the processor datapath. It generalises the 16×32 two-read/one-write file by adding configurable width, depth and read-port count, a second write port for link-register writes, and pending-write tracking for hazard stalls.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- RD_PORTS, 2, number of read ports (1..4)
- ZERO_REG, 0, 1 = register 0 hardwired to zero, never written, never busy

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_ld  in  1  load enable for all read output registers
- rd_clr  in  1  synchronous clear of all read output registers
- rd_addr  in  RD_PORTS*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- rd_data  out  RD_PORTS*DATA_W  registered read data, same packing
- rd_busy  out  RD_PORTS  registered busy flag of each addressed register
- stall  out  1  combinational OR of current-cycle busy of every rd_addr
- wr0_en, wr0_addr, wr0_data  in  1, ADDR_W, DATA_W  writeback port (ALU/load result)
- wr1_en, wr1_addr, wr1_data  in  1, ADDR_W, DATA_W  link port (call return address)
- iss_en  in  1  instruction issue marks destination pending
- iss_addr  in  ADDR_W  destination being issued

## Operation
- Storage: DEPTH × DATA_W flops; busy: DEPTH-bit vector.
- Write: on edge, wr0_en writes wr0_addr; wr1_en writes wr1_addr. Both enabled to same address: wr1 wins.
- Scoreboard: write on either port clears busy[addr]; iss_en sets busy[iss_addr]. Issue and write to same address same cycle: busy ends 1 (new writer outstanding).
- Read port p, on edge: rd_clr → rd_data/rd_busy = 0; else rd_ld → capture. rd_clr beats rd_ld. Neither → hold.
- Captured value: wr1 data if wr1_en and wr1_addr matches; else wr0 data if wr0_en and matches; else stored value (bypass, same priority as write).
- Captured busy: busy[rd_addr] after this edge's update (write clears, issue sets, issue wins).
- stall uses pre-edge busy with write-clear applied (writeback in flight resolves hazard); issue in same cycle does not raise stall.
- ZERO_REG=1: writes to address 0 dropped, iss_en to address 0 ignored, reads of 0 return 0, busy 0 — including bypass path.
- Out-of-range addresses impossible (DEPTH = 2**ADDR_W).

## Timing
- Reset (rst=1 at edge): all registers 0, busy all 0, rd_data 0, rd_busy 0. rst overrides writes, issue, rd_ld the same cycle. stall = 0 the cycle after reset.
- Read latency: 1 cycle from rd_addr/rd_ld to rd_data.
- Write-to-read: 0 extra cycles via bypass; storage visible to non-bypassed reads the next cycle.
- Issue-to-busy: busy visible on stall the cycle after iss_en.
- Reset mid-operation: pending busy bits discarded; later writebacks to those addresses are ordinary writes.

## Structure
- Package regfile_pkg: default DATA_W/ADDR_W/RD_PORTS constants and the link register index constant (DEPTH-1) used by decode to drive wr1_addr.
- Sub-module rf_read_port: one registered read port (bypass mux, ld/clr output flop, busy capture), generated RD_PORTS times.
- Top holds storage, busy vector, write/issue logic and stall reduction.

## Test plan
- Reset: load r3=0x1234, assert rst → rd of r3 with rd_ld gives 0x0, rd_busy=0, stall=0.
- Write/read: wr0 r5=0xDEADBEEF, next cycle rd_addr0=5, rd_ld → rd_data port0 = 0xDEADBEEF after 1 cycle.
- Bypass and port priority: same cycle wr0 r7=0x11, wr1 r7=0x22, rd_addr1=7, rd_ld → rd_data port1 = 0x22, stored r7 = 0x22.
- Scoreboard: iss_en r2, next cycle rd_addr0=2 → stall=1; wr0 r2=0x99 that cycle → stall=0, captured data 0x99, rd_busy=0.
- Issue/write collision: busy r4, same cycle wr0 r4 and iss_en r4 → busy[r4] stays 1, stall=1 next cycle on read of r4.
- ZERO_REG=1: wr0 r0=0xFFFF, iss_en r0 → read r0 gives 0, rd_busy=0, stall=0; rd_clr with rd_ld clears all outputs to 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the register file and the link-register index that
// decode drives onto wr1_addr for call instructions.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 4;
    localparam int unsigned RD_PORTS_DEF = 2;

    // Link register is the top register of the file.
    function automatic int unsigned link_reg_idx(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

    localparam int unsigned LINK_REG = link_reg_idx(ADDR_W_DEF);

endpackage

// File: rtl/regfile_sb_rf_read_port.sv
// One registered read port: write-bypass mux, clear/load output register,
// and capture of the post-update busy bit of the addressed register.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              busy_next,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    logic [DATA_W-1:0] fwd;

    // Bypass in the same priority order as the storage write (wr1 over wr0).
    always_comb begin
        fwd = stored;
        if (we1 && (wr1_addr == addr)) begin
            fwd = wr1_data;
        end else if (we0 && (wr0_addr == addr)) begin
            fwd = wr0_data;
        end
    end

    // Output register: reset and clear dominate load; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            data <= '0;
            busy <= 1'b0;
        end else if (ld) begin
            data <= fwd;
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with registered reads, same-cycle write
// bypass, two write ports (wr1 = link port, wins on address clash) and a
// per-register pending-write scoreboard driving the hazard stall.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RD_PORTS = RD_PORTS_DEF,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_ld,
    input  logic                       rd_clr,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [RD_PORTS*DATA_W-1:0] rd_data,
    output logic [RD_PORTS-1:0]        rd_busy,
    output logic                       stall,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_clr;
    logic [DEPTH-1:0]  busy_next;
    logic              we0;
    logic              we1;
    logic              ise;

    // Register 0 gating: with ZERO_REG set, writes and issues to r0 are
    // dropped here, so r0 storage stays at its reset zero and never goes busy;
    // the read ports then need no special case, bypass included.
    always_comb begin
        we0 = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
        we1 = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));
        ise = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));
    end

    // Storage write; wr1 is assigned last so it wins an address clash.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we0) regs[wr0_addr] <= wr0_data;
            if (we1) regs[wr1_addr] <= wr1_data;
        end
    end

    // Scoreboard update: writebacks clear first, then a new issue sets.
    always_comb begin
        busy_clr = busy;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((we0 && (wr0_addr == ADDR_W'(i))) || (we1 && (wr1_addr == ADDR_W'(i)))) begin
                busy_clr[i] = 1'b0;
            end
        end
        busy_next = busy_clr;
        if (ise) begin
            busy_next[iss_addr] = 1'b1;
        end
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Stall sees in-flight writebacks but not a same-cycle issue.
    always_comb begin
        stall = 1'b0;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            stall = stall | busy_clr[rd_addr[p*ADDR_W +: ADDR_W]];
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .ld        (rd_ld),
            .clr       (rd_clr),
            .addr      (addr),
            .stored    (regs[addr]),
            .busy_next (busy_next[addr]),
            .we0       (we0),
            .wr0_addr  (wr0_addr),
            .wr0_data  (wr0_data),
            .we1       (we1),
            .wr1_addr  (wr1_addr),
            .wr1_data  (wr1_data),
            .data      (rd_data[p*DATA_W +: DATA_W]),
            .busy      (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: two instances (ZERO_REG=0 and 1) share
// stimulus; expected read/stall values are queued with the cycle they become
// visible and a monitor compares them at the falling edge.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_ld;
    logic        rd_clr;
    logic [7:0]  rd_addr;
    logic        wr0_en;
    logic [3:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [3:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic        iss_en;
    logic [3:0]  iss_addr;

    logic [63:0] rd_data_a, rd_data_z;
    logic [1:0]  rd_busy_a, rd_busy_z;
    logic        stall_a, stall_z;

    typedef struct {
        int          cyc;
        int          which;   // 0: ZERO_REG=0 instance, 1: ZERO_REG=1 instance
        int          kind;    // 0: read port, 1: stall
        int          port;
        int          tag;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   tag   = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(4), .RD_PORTS(2), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .rd_ld(rd_ld), .rd_clr(rd_clr), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_busy(rd_busy_a), .stall(stall_a),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(4), .RD_PORTS(2), .ZERO_REG(1)) dutz (
        .clk(clk), .rst(rst), .rd_ld(rd_ld), .rd_clr(rd_clr), .rd_addr(rd_addr),
        .rd_data(rd_data_z), .rd_busy(rd_busy_z), .stall(stall_z),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: compare every queued expectation due in the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t        e;
                logic [63:0] dv;
                logic [1:0]  bv;
                logic [31:0] ad;
                logic        ab;
                logic        st;
                e  = sb.pop_front();
                dv = (e.which == 0) ? rd_data_a : rd_data_z;
                bv = (e.which == 0) ? rd_busy_a : rd_busy_z;
                st = (e.which == 0) ? stall_a : stall_z;
                tests++;
                if (e.kind == 1) begin
                    if (st !== e.busy) begin
                        fails++;
                        $display("FAIL stall step%0d dut%0d cyc%0d: got %b expected %b",
                                 e.tag, e.which, cyc, st, e.busy);
                    end
                end else begin
                    ad = dv[e.port*32 +: 32];
                    ab = bv[e.port];
                    if (ad !== e.data || ab !== e.busy) begin
                        fails++;
                        $display("FAIL rd step%0d dut%0d port%0d cyc%0d: got %h/%b expected %h/%b",
                                 e.tag, e.which, e.port, cyc, ad, ab, e.data, e.busy);
                    end
                end
            end
        end
    end

    task automatic push_rd(input int w, input int p, input logic [31:0] d, input logic b);
        exp_t e;
        e.cyc = cyc + 1; e.which = w; e.kind = 0; e.port = p; e.tag = tag;
        e.data = d; e.busy = b;
        sb.push_back(e);
    endtask

    task automatic rd2(input int p, input logic [31:0] d, input logic b);
        push_rd(0, p, d, b);
        push_rd(1, p, d, b);
    endtask

    task automatic push_stall(input int w, input logic s);
        exp_t e;
        e.cyc = cyc; e.which = w; e.kind = 1; e.port = 0; e.tag = tag;
        e.data = '0; e.busy = s;
        sb.push_back(e);
    endtask

    task automatic stall2(input logic s);
        push_stall(0, s);
        push_stall(1, s);
    endtask

    task automatic idle();
        rst = 1'b0; rd_ld = 1'b0; rd_clr = 1'b0;
        wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
        tag++;
    endtask

    task automatic ra(input logic [3:0] a0, input logic [3:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic w0(input logic [3:0] a, input logic [31:0] d);
        wr0_en = 1'b1; wr0_addr = a; wr0_data = d;
    endtask

    task automatic w1(input logic [3:0] a, input logic [31:0] d);
        wr1_en = 1'b1; wr1_addr = a; wr1_data = d;
    endtask

    task automatic iss(input logic [3:0] a);
        iss_en = 1'b1; iss_addr = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] lr;
        lr = 4'(LINK_REG);
        idle(); rst = 1'b1; ra(0, 0);
        wr0_addr = '0; wr0_data = '0; wr1_addr = '0; wr1_data = '0; iss_addr = '0;
        step(); step();

        // A: load r3 before reset
        idle(); w0(3, 32'h1234); step();
        // B: reset overrides write, issue and load
        idle(); rst = 1'b1; w0(3, 32'h5555); iss(3); ra(3, 3); rd_ld = 1'b1;
        stall2(1'b0); rd2(0, 32'h0, 1'b0); rd2(1, 32'h0, 1'b0); step();
        // C: r3 cleared, not busy
        idle(); ra(3, 3); rd_ld = 1'b1;
        stall2(1'b0); rd2(0, 32'h0, 1'b0); rd2(1, 32'h0, 1'b0); step();
        // D: write r5, outputs hold
        idle(); w0(5, 32'hDEADBEEF);
        rd2(0, 32'h0, 1'b0); step();
        // E: read r5 from storage
        idle(); ra(5, 3); rd_ld = 1'b1;
        rd2(0, 32'hDEADBEEF, 1'b0); rd2(1, 32'h0, 1'b0); step();
        // F: both ports write r7, bypass to port1, wr1 wins
        idle(); w0(7, 32'h11); w1(7, 32'h22); ra(5, 7); rd_ld = 1'b1;
        rd2(0, 32'hDEADBEEF, 1'b0); rd2(1, 32'h22, 1'b0); step();
        // G: stored r7 is wr1 value
        idle(); ra(7, 7); rd_ld = 1'b1;
        rd2(0, 32'h22, 1'b0); rd2(1, 32'h22, 1'b0); step();
        // H: issue r2, same-cycle issue does not stall, captured busy set
        idle(); iss(2); ra(2, 7); rd_ld = 1'b1;
        stall2(1'b0); rd2(0, 32'h0, 1'b1); rd2(1, 32'h22, 1'b0); step();
        // I: r2 pending -> stall
        idle(); ra(2, 7); rd_ld = 1'b1;
        stall2(1'b1); rd2(0, 32'h0, 1'b1); step();
        // J: writeback resolves hazard same cycle
        idle(); w0(2, 32'h99); ra(2, 7); rd_ld = 1'b1;
        stall2(1'b0); rd2(0, 32'h99, 1'b0); step();
        // K: link register write via wr1, bypassed to port1
        idle(); w1(lr, 32'hCAFE0000); ra(2, lr); rd_ld = 1'b1;
        stall2(1'b0); rd2(0, 32'h99, 1'b0); rd2(1, 32'hCAFE0000, 1'b0); step();
        // L: issue r4, outputs hold
        idle(); iss(4);
        stall2(1'b0); rd2(0, 32'h99, 1'b0); rd2(1, 32'hCAFE0000, 1'b0); step();
        // M: write and issue r4 together -> stays busy
        idle(); w0(4, 32'h44); iss(4); ra(4, lr); rd_ld = 1'b1;
        stall2(1'b0); rd2(0, 32'h44, 1'b1); rd2(1, 32'hCAFE0000, 1'b0); step();
        // N: r4 still busy
        idle(); ra(4, lr); rd_ld = 1'b1;
        stall2(1'b1); rd2(0, 32'h44, 1'b1); step();
        // O: link-port write also clears busy
        idle(); w1(4, 32'h55); ra(4, lr); rd_ld = 1'b1;
        stall2(1'b0); rd2(0, 32'h55, 1'b0); step();
        // P: clear beats load
        idle(); rd_clr = 1'b1; rd_ld = 1'b1;
        rd2(0, 32'h0, 1'b0); rd2(1, 32'h0, 1'b0); step();
        // Q: no load -> hold cleared values
        idle(); ra(5, lr);
        rd2(0, 32'h0, 1'b0); rd2(1, 32'h0, 1'b0); step();
        // R: write and issue r0
        idle(); w0(0, 32'hFFFF); iss(0); ra(0, lr); rd_ld = 1'b1;
        stall2(1'b0);
        push_rd(0, 0, 32'hFFFF, 1'b1); push_rd(1, 0, 32'h0, 1'b0);
        rd2(1, 32'hCAFE0000, 1'b0); step();
        // S: r0 busy only without hardwired zero
        idle(); ra(0, lr); rd_ld = 1'b1;
        push_stall(0, 1'b1); push_stall(1, 1'b0);
        push_rd(0, 0, 32'hFFFF, 1'b1); push_rd(1, 0, 32'h0, 1'b0); step();
        // T: link-port write to r0
        idle(); w1(0, 32'hABCD); ra(0, lr); rd_ld = 1'b1;
        stall2(1'b0);
        push_rd(0, 0, 32'hABCD, 1'b0); push_rd(1, 0, 32'h0, 1'b0); step();
        // U: issue r6
        idle(); iss(6);
        stall2(1'b0); step();
        // V: r6 pending -> stall; reset discards it
        idle(); rst = 1'b1; ra(6, lr);
        stall2(1'b1); rd2(0, 32'h0, 1'b0); rd2(1, 32'h0, 1'b0); step();
        // W: after reset no stall, storage cleared
        idle(); ra(6, lr); rd_ld = 1'b1;
        stall2(1'b0); rd2(0, 32'h0, 1'b0); rd2(1, 32'h0, 1'b0); step();
        // X: later writeback to r6 is an ordinary write
        idle(); w0(6, 32'h66); ra(6, lr); rd_ld = 1'b1;
        stall2(1'b0); rd2(0, 32'h66, 1'b0); step();

        idle();
        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations never compared, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
